// File: rtl/bash_hash_arb.sv
// bash_hash_arb: round-robin arbiter sharing one bash-f permutation core
// among NREQ requesters. Sequence per grant: IDLE -> LOAD -> START -> BUSY -> DONE.
//
// Ports:
//   clk_i         clock, rising edge
//   rst_ni        synchronous active-low reset
//   req_i         per-requester request, held until its done_o pulse
//   grant_o       one-hot owner, valid LOAD..DONE, zero in IDLE
//   sel_o         binary owner index for the core input mux
//   done_o        one-cycle completion pulse to the owner
//   core_prep_o   one-cycle block-load pulse to the core
//   core_start_o  one-cycle start pulse to the core
//   core_rdy_i    core ready (low while permuting)
//   busy_o        high in every state except IDLE
//   err_o         one-cycle watchdog timeout pulse
//
// Optional feature: define BASH_ARB_WDOG_EN to enable the BUSY watchdog
// (limit TIMEOUT cycles). Without it err_o is constant 0 and BUSY waits forever.
module bash_hash_arb #(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned TIMEOUT = 31
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NREQ-1:0]         req_i,
  output logic [NREQ-1:0]         grant_o,
  output logic [$clog2(NREQ)-1:0] sel_o,
  output logic [NREQ-1:0]         done_o,
  output logic                    core_prep_o,
  output logic                    core_start_o,
  input  logic                    core_rdy_i,
  output logic                    busy_o,
  output logic                    err_o
);

  localparam int unsigned SEL_W = $clog2(NREQ);
  localparam int unsigned WD_W  = 5;

  if (NREQ < 2 || NREQ > 4) begin : g_bad_nreq
    $error("bash_hash_arb: NREQ must be 2..4");
  end
  if (TIMEOUT < 1 || TIMEOUT > 31) begin : g_bad_timeout
    $error("bash_hash_arb: TIMEOUT must be 1..31");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_BUSY  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  owner_q, owner_d;
  logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              seen_low_q, seen_low_d;
  logic [SEL_W-1:0]  win, cand, ptr_next;
  logic              found;
  logic              timeout;

  logic [NREQ-1:0]   grant_d, done_d;
  logic [SEL_W-1:0]  sel_d;
  logic              prep_d, start_d, busy_d, err_d;

`ifdef BASH_ARB_WDOG_EN
  logic [WD_W-1:0]   wdog_q, wdog_d;
`endif

  // Round-robin pick: first requester at or after rr_ptr, wrapping to 0.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = SEL_W'((32'(rr_ptr_q) + i) % NREQ);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign ptr_next = SEL_W'((32'(owner_q) + 32'd1) % NREQ);

  // Next state plus next-cycle output values decoded from the next state.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    seen_low_d = seen_low_q;
    timeout    = 1'b0;
`ifdef BASH_ARB_WDOG_EN
    wdog_d     = wdog_q;
`endif
    grant_d    = '0;
    sel_d      = '0;
    done_d     = '0;
    prep_d     = 1'b0;
    start_d    = 1'b0;
    busy_d     = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (found) begin
          owner_d = win;
          state_d = S_LOAD;
        end
      end
      S_LOAD:  state_d = S_START;
      S_START: begin
        state_d    = S_BUSY;
        seen_low_d = 1'b0;
`ifdef BASH_ARB_WDOG_EN
        wdog_d     = '0;
`endif
      end
      S_BUSY: begin
        if (!core_rdy_i) seen_low_d = 1'b1;
        // rdy only counts once the core has been seen low in this BUSY
        if (core_rdy_i && seen_low_q) begin
          state_d = S_DONE;
        end else begin
`ifdef BASH_ARB_WDOG_EN
          if (wdog_q == WD_W'(TIMEOUT - 1)) begin
            timeout  = 1'b1;
            rr_ptr_d = ptr_next;
            state_d  = S_IDLE;
          end else begin
            wdog_d = wdog_q + WD_W'(1);
          end
`endif
        end
      end
      S_DONE: begin
        rr_ptr_d = ptr_next;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != S_IDLE) begin
      grant_d = NREQ'(1) << owner_d;
      sel_d   = owner_d;
      busy_d  = 1'b1;
    end
    if (state_d == S_DONE) done_d = NREQ'(1) << owner_d;
    prep_d  = (state_d == S_LOAD);
    start_d = (state_d == S_START);
    err_d   = timeout;
  end

  // State and registered outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      owner_q      <= '0;
      rr_ptr_q     <= '0;
      seen_low_q   <= 1'b0;
      grant_o      <= '0;
      sel_o        <= '0;
      done_o       <= '0;
      core_prep_o  <= 1'b0;
      core_start_o <= 1'b0;
      busy_o       <= 1'b0;
      err_o        <= 1'b0;
`ifdef BASH_ARB_WDOG_EN
      wdog_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      rr_ptr_q     <= rr_ptr_d;
      seen_low_q   <= seen_low_d;
      grant_o      <= grant_d;
      sel_o        <= sel_d;
      done_o       <= done_d;
      core_prep_o  <= prep_d;
      core_start_o <= start_d;
      busy_o       <= busy_d;
      err_o        <= err_d;
`ifdef BASH_ARB_WDOG_EN
      wdog_q       <= wdog_d;
`endif
    end
  end

endmodule

// File: tb/tb_bash_hash_arb.sv
// Testbench for bash_hash_arb (NREQ=2). Inputs change and outputs are
// sampled on the falling clock edge; the bench plays the core's rdy line.
module tb_bash_hash_arb;

  localparam int unsigned NREQ    = 2;
  localparam int unsigned TIMEOUT = 31;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic [NREQ-1:0] req_i;
  logic [NREQ-1:0] grant_o;
  logic            sel_o;
  logic [NREQ-1:0] done_o;
  logic            core_prep_o;
  logic            core_start_o;
  logic            core_rdy_i;
  logic            busy_o;
  logic            err_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  bash_hash_arb #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_i        (req_i),
    .grant_o      (grant_o),
    .sel_o        (sel_o),
    .done_o       (done_o),
    .core_prep_o  (core_prep_o),
    .core_start_o (core_start_o),
    .core_rdy_i   (core_rdy_i),
    .busy_o       (busy_o),
    .err_o        (err_o)
  );

  // One transaction: request, owner expected, drop mask applied in BUSY,
  // req value after done, core low time, rdy high in first BUSY cycle.
  typedef struct {
    logic [1:0] req;
    logic [1:0] drop;
    logic [1:0] after;
    int         lat;
    bit         early;
    int         owner;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Starts at a falling edge with the DUT in IDLE; ends in the following IDLE.
  task automatic txn(input vec_t v);
    logic [1:0] oh;
    int npre;
    oh   = 2'b01 << v.owner;
    npre = v.early ? 1 : 0;
    req_i      = v.req;
    core_rdy_i = 1'b1;
    @(negedge clk_i);
    chk("load_prep",  32'(core_prep_o), 1);
    chk("load_start", 32'(core_start_o), 0);
    chk("load_grant", 32'(grant_o), 32'(oh));
    chk("load_sel",   32'(sel_o), 32'(v.owner));
    chk("load_busy",  32'(busy_o), 1);
    @(negedge clk_i);
    chk("start_start", 32'(core_start_o), 1);
    chk("start_prep",  32'(core_prep_o), 0);
    chk("start_grant", 32'(grant_o), 32'(oh));
    for (int k = 0; k <= npre + v.lat; k++) begin
      @(negedge clk_i);
      chk("busy_done",  32'(done_o), 0);
      chk("busy_grant", 32'(grant_o), 32'(oh));
      chk("busy_busy",  32'(busy_o), 1);
      if (k == 1) req_i = v.req & ~v.drop;
      core_rdy_i = (k < npre) ? 1'b1 : ((k < npre + v.lat) ? 1'b0 : 1'b1);
    end
    @(negedge clk_i);
    chk("done_done",  32'(done_o), 32'(oh));
    chk("done_grant", 32'(grant_o), 32'(oh));
    chk("done_busy",  32'(busy_o), 1);
    chk("done_err",   32'(err_o), 0);
    req_i = v.after;
    @(negedge clk_i);
    chk("idle_busy",  32'(busy_o), 0);
    chk("idle_grant", 32'(grant_o), 0);
    chk("idle_done",  32'(done_o), 0);
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{2'b01, 2'b00, 2'b00, 24, 1'b0, 0};  // first grant after reset
    vecs[1] = '{2'b11, 2'b00, 2'b11,  3, 1'b0, 1};  // held 11 alternates
    vecs[2] = '{2'b11, 2'b00, 2'b11,  2, 1'b0, 0};
    vecs[3] = '{2'b11, 2'b00, 2'b00,  1, 1'b0, 1};
    vecs[4] = '{2'b01, 2'b00, 2'b00, 24, 1'b1, 0};  // rdy high in first BUSY cycle
    vecs[5] = '{2'b11, 2'b10, 2'b01,  4, 1'b0, 1};  // owner drops req in BUSY
    vecs[6] = '{2'b01, 2'b00, 2'b00,  2, 1'b0, 0};  // pending loser served
    vecs[7] = '{2'b01, 2'b00, 2'b00,  1, 1'b0, 0};  // pointer at 1 wraps to 0

    rst_ni     = 1'b0;
    req_i      = '0;
    core_rdy_i = 1'b1;
    repeat (2) @(negedge clk_i);
    chk("rst_grant", 32'(grant_o), 0);
    chk("rst_sel",   32'(sel_o), 0);
    chk("rst_done",  32'(done_o), 0);
    chk("rst_prep",  32'(core_prep_o), 0);
    chk("rst_start", 32'(core_start_o), 0);
    chk("rst_busy",  32'(busy_o), 0);
    chk("rst_err",   32'(err_o), 0);
    rst_ni = 1'b1;

    foreach (vecs[i]) txn(vecs[i]);

    // Reset in BUSY while requester 1 owns the core (pointer is 1 here).
    req_i = 2'b10;
    @(negedge clk_i);
    chk("mid_load_grant", 32'(grant_o), 32'b10);
    @(negedge clk_i);
    @(negedge clk_i);
    core_rdy_i = 1'b0;
    @(negedge clk_i);
    chk("mid_busy", 32'(busy_o), 1);
    rst_ni     = 1'b0;
    req_i      = 2'b11;
    core_rdy_i = 1'b1;
    @(negedge clk_i);
    chk("mrst_grant", 32'(grant_o), 0);
    chk("mrst_sel",   32'(sel_o), 0);
    chk("mrst_done",  32'(done_o), 0);
    chk("mrst_busy",  32'(busy_o), 0);
    chk("mrst_prep",  32'(core_prep_o), 0);
    chk("mrst_start", 32'(core_start_o), 0);
    chk("mrst_err",   32'(err_o), 0);
    @(negedge clk_i);
    chk("mrst_done2", 32'(done_o), 0);
    rst_ni = 1'b1;
    txn('{2'b11, 2'b00, 2'b10, 3, 1'b0, 0});  // pointer back at 0
    txn('{2'b10, 2'b00, 2'b00, 3, 1'b0, 1});  // requester 1 re-granted

`ifdef BASH_ARB_WDOG_EN
    // Core never finishes: err after TIMEOUT BUSY cycles, no done.
    req_i = 2'b01;
    @(negedge clk_i);
    chk("wd_load_grant", 32'(grant_o), 32'b01);
    @(negedge clk_i);
    for (int k = 0; k < int'(TIMEOUT); k++) begin
      @(negedge clk_i);
      chk("wd_busy_busy", 32'(busy_o), 1);
      chk("wd_busy_err",  32'(err_o), 0);
      core_rdy_i = 1'b0;
    end
    @(negedge clk_i);
    chk("wd_err",   32'(err_o), 1);
    chk("wd_done",  32'(done_o), 0);
    chk("wd_busy",  32'(busy_o), 0);
    chk("wd_grant", 32'(grant_o), 0);
    req_i      = '0;
    core_rdy_i = 1'b1;
    @(negedge clk_i);
    chk("wd_err_pulse", 32'(err_o), 0);
`else
    // Without the watchdog a long core run still completes normally.
    txn('{2'b01, 2'b00, 2'b00, 40, 1'b0, 0});
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
